// File: rtl/fir_out_fifo.sv
// fir_out_fifo: first-word-fall-through output buffer behind the FIR filter.
// The FIR has no backpressure. Samples that arrive while the buffer is full
// (and nothing is popped in the same cycle) are dropped and flagged in a
// sticky overflow bit. Stored data is never overwritten by a dropped sample.
// All outputs are decoded from registers only.
module fir_out_fifo #(
    parameter int DW    = 14,
    parameter int DEPTH = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [DW-1:0]      DIN,
    input  logic               VIN,
    output logic [DW-1:0]      DOUT,
    output logic               VOUT,
    input  logic               READY,
    output logic [$clog2(DEPTH):0] COUNT,
    output logic               FULL,
    output logic               EMPTY,
    output logic               OVF,
    input  logic               CLR_OVF
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LP_FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic          r_ovf;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Status flags come from the occupancy register, never from the pointers.
    always_comb begin
        w_full  = (r_count == LP_FULL_CNT);
        w_empty = (r_count == '0);
        // READY has no effect while nothing is presented.
        w_pop   = ~w_empty & READY;
        // A full buffer still accepts a sample if the head leaves this cycle.
        w_push  = VIN & (~w_full | w_pop);
        w_drop  = VIN & w_full & ~w_pop;
    end

    // Sample storage; contents survive reset, only the pointers are cleared.
    always_ff @(posedge CLK) begin
        if (!RST && w_push) begin
            r_mem[r_wp] <= DIN;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow: a new drop outranks a clear in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (CLR_OVF) begin
            r_ovf <= 1'b0;
        end
    end

    // Output decode; DOUT reads as zero whenever nothing valid is presented.
    always_comb begin
        VOUT  = ~w_empty;
        DOUT  = w_empty ? '0 : r_mem[r_rp];
        COUNT = r_count;
        FULL  = w_full;
        EMPTY = w_empty;
        OVF   = r_ovf;
    end

endmodule

// File: tb/tb_fir_out_fifo.sv
// Bench for fir_out_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fir_out_fifo;

    localparam int DW    = 14;
    localparam int DEPTH = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [DW-1:0] DIN = '0;
    logic          VIN = 1'b0;
    logic          READY = 1'b0;
    logic          CLR_OVF = 1'b0;
    logic [DW-1:0] DOUT;
    logic          VOUT;
    logic [3:0]    COUNT;
    logic          FULL;
    logic          EMPTY;
    logic          OVF;

    int total = 0;
    int bad   = 0;

    fir_out_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .DIN(DIN), .VIN(VIN), .DOUT(DOUT), .VOUT(VOUT),
        .READY(READY), .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY), .OVF(OVF),
        .CLR_OVF(CLR_OVF)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: an ordered queue of stored samples plus the sticky flag.
    logic [DW-1:0] mq[$];
    bit            m_ovf   = 0;
    bit            m_valid = 0;

    always @(posedge CLK) begin
        if (RST) begin
            mq.delete();
            m_ovf   = 0;
            m_valid = 1;
        end else if (m_valid) begin
            int  sz;
            bit  pop;
            bit  drop;
            sz   = mq.size();
            pop  = (sz > 0) && READY;
            drop = 0;
            if (pop) void'(mq.pop_front());
            if (VIN) begin
                if (sz < DEPTH || pop) mq.push_back(DIN);
                else drop = 1;
            end
            if (drop)         m_ovf = 1;
            else if (CLR_OVF) m_ovf = 0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (m_valid) begin
            chk("m_count", 32'(COUNT), 32'(mq.size()));
            chk("m_vout",  32'(VOUT),  32'(mq.size() != 0));
            chk("m_empty", 32'(EMPTY), 32'(mq.size() == 0));
            chk("m_full",  32'(FULL),  32'(mq.size() == DEPTH));
            chk("m_ovf",   32'(OVF),   32'(m_ovf));
            chk("m_dout",  32'(DOUT),  (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        end
    end

    // Apply inputs for one rising edge, then settle just after it.
    task automatic cyc(input bit vin, input logic [DW-1:0] din, input bit rdy, input bit clr);
        VIN = vin; DIN = din; READY = rdy; CLR_OVF = clr;
        @(posedge CLK);
        #1;
        VIN = 0; DIN = '0; READY = 0; CLR_OVF = 0;
    endtask

    initial begin
        logic [DW-1:0] t1 [3];
        logic [DW-1:0] s;
        t1[0] = 14'h0001; t1[1] = 14'h1FFF; t1[2] = 14'h2000;

        // reset
        RST = 1;
        cyc(0, '0, 0, 0);
        RST = 0;
        chk("rst_count", 32'(COUNT), 0);
        chk("rst_empty", 32'(EMPTY), 1);
        chk("rst_full",  32'(FULL),  0);
        chk("rst_vout",  32'(VOUT),  0);
        chk("rst_dout",  32'(DOUT),  0);
        chk("rst_ovf",   32'(OVF),   0);

        // three samples held, then drained back-to-back
        for (int i = 0; i < 3; i++) cyc(1, t1[i], 0, 0);
        chk("t1_count", 32'(COUNT), 3);
        chk("t1_vout",  32'(VOUT),  1);
        chk("t1_head",  32'(DOUT),  32'h0001);
        for (int i = 0; i < 3; i++) begin
            chk("t1_drain", 32'(DOUT), 32'(t1[i]));
            cyc(0, '0, 1, 0);
        end
        chk("t1_empty", 32'(EMPTY), 1);
        chk("t1_dout0", 32'(DOUT),  0);

        // overflow: ninth sample dropped
        for (int i = 0; i < 8; i++) cyc(1, 14'(16'h0100 + i), 0, 0);
        cyc(1, 14'h3FFF, 0, 0);
        chk("t2_full",  32'(FULL),  1);
        chk("t2_count", 32'(COUNT), 8);
        chk("t2_ovf",   32'(OVF),   1);
        for (int i = 0; i < 8; i++) begin
            chk("t2_drain", 32'(DOUT), 32'h0100 + i);
            cyc(0, '0, 1, 0);
        end
        chk("t2_empty", 32'(EMPTY), 1);
        cyc(0, '0, 0, 1);
        chk("t2_clr", 32'(OVF), 0);

        // full with simultaneous push and pop for 20 cycles
        for (int i = 0; i < 8; i++) cyc(1, 14'(16'h0200 + i), 0, 0);
        for (int i = 0; i < 20; i++) begin
            chk("t3_head", 32'(DOUT), (i < 8) ? 32'h0200 + i : 32'h0300 + i - 8);
            cyc(1, 14'(16'h0300 + i), 1, 0);
            chk("t3_count", 32'(COUNT), 8);
            chk("t3_ovf",   32'(OVF),   0);
        end
        for (int i = 0; i < 8; i++) begin
            chk("t3_drain", 32'(DOUT), 32'h0300 + 12 + i);
            cyc(0, '0, 1, 0);
        end

        // 32 samples with alternating push / pop, pointers wrap 4 times
        for (int i = 0; i < 32; i++) begin
            s = 14'((i * 37 + 5) ^ 16'h2A55);
            cyc(1, s, 0, 0);
            chk("t4_count1", 32'(COUNT), 1);
            chk("t4_head",   32'(DOUT),  32'(s));
            cyc(0, '0, 1, 0);
            chk("t4_count0", 32'(COUNT), 0);
        end
        chk("t4_ovf", 32'(OVF), 0);

        // clear colliding with an overflow push, then clear alone
        for (int i = 0; i < 8; i++) cyc(1, 14'(16'h0500 + i), 0, 0);
        cyc(1, 14'h3FFF, 0, 1);
        chk("t5_setwins", 32'(OVF), 1);
        cyc(0, '0, 0, 1);
        chk("t5_clr", 32'(OVF), 0);

        // reset mid-operation with VIN high
        cyc(1, 14'h3FFF, 0, 0);
        chk("t6_ovf_pre", 32'(OVF), 1);
        for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0);
        chk("t6_count5", 32'(COUNT), 5);
        RST = 1;
        cyc(1, 14'h1234, 0, 0);
        RST = 0;
        chk("t6_count", 32'(COUNT), 0);
        chk("t6_vout",  32'(VOUT),  0);
        chk("t6_dout",  32'(DOUT),  0);
        chk("t6_ovf",   32'(OVF),   0);
        cyc(1, 14'h0ABC, 0, 0);
        chk("t6_head",  32'(DOUT),  32'h0ABC);
        chk("t6_vout1", 32'(VOUT),  1);
        chk("t6_cnt1",  32'(COUNT), 1);
        cyc(0, '0, 1, 0);
        chk("t6_end", 32'(EMPTY), 1);

        @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
